// File: rtl/rx_uart_if.sv
// Receive-side bundle between the UART deframer and its FIFO/host logic.
// The master modport is the receiver; the slave modport is the host/FIFO side.
interface rx_uart_if;
    logic       rxData;
    logic       full;
    logic       clrErr;
    logic [7:0] din;
    logic       wrEn;
    logic       frameErr;
    logic       overrun;
    logic       busy;

    modport master (
        input  rxData, full, clrErr,
        output din, wrEn, frameErr, overrun, busy
    );

    modport slave (
        output rxData, full, clrErr,
        input  din, wrEn, frameErr, overrun, busy
    );
endinterface

// File: rtl/rx_uart.sv
// 8N1 UART receiver: 16x oversampling from a free-running tick divider,
// one-clk FIFO write strobe per good byte, and sticky framing/overrun flags.
module rx_uart #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned TICK_COUNT = CLK_FREQ / (BAUD_RATE * OVERSAMPLE) - 1
) (
    input logic          clk,
    input logic          rst,
    rx_uart_if.master    bus
);

    localparam int unsigned TickW = (TICK_COUNT > 0) ? $clog2(TICK_COUNT + 1) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWrite,
        StBreak
    } state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic               r_sync1;
    logic               r_sync2;
    logic [TickW-1:0]   r_tick_cnt;
    logic [3:0]         r_sample_cnt;
    logic [3:0]         w_sample_cnt_next;
    logic [2:0]         r_bit_idx;
    logic [2:0]         w_bit_idx_next;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_next;
    logic [7:0]         r_din;
    logic [7:0]         w_din_next;
    logic               r_wr_en;
    logic               w_wr_en_next;
    logic               r_frame_err;
    logic               r_overrun;
    logic               w_set_frame;
    logic               w_set_overrun;
    logic               w_rx_sync;
    logic               w_tick;

    assign w_rx_sync = r_sync2;
    assign w_tick    = (r_tick_cnt == TickW'(TICK_COUNT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_tick_cnt   <= '0;
            r_state      <= StIdle;
            r_sample_cnt <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_din        <= '0;
            r_wr_en      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_sync1      <= bus.rxData;
            r_sync2      <= r_sync1;
            r_tick_cnt   <= w_tick ? '0 : r_tick_cnt + TickW'(1);
            r_state      <= w_state_next;
            r_sample_cnt <= w_sample_cnt_next;
            r_bit_idx    <= w_bit_idx_next;
            r_shift      <= w_shift_next;
            r_din        <= w_din_next;
            r_wr_en      <= w_wr_en_next;
            // A set in the same cycle as clrErr wins.
            r_frame_err  <= (r_frame_err & ~bus.clrErr) | w_set_frame;
            r_overrun    <= (r_overrun & ~bus.clrErr) | w_set_overrun;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_sample_cnt_next = r_sample_cnt;
        w_bit_idx_next    = r_bit_idx;
        w_shift_next      = r_shift;
        w_din_next        = r_din;
        w_wr_en_next      = 1'b0;
        w_set_frame       = 1'b0;
        w_set_overrun     = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_tick && !w_rx_sync) begin
                    w_state_next      = StStart;
                    w_sample_cnt_next = '0;
                end
            end
            StStart: begin
                if (w_tick) begin
                    if (r_sample_cnt == 4'd7) begin
                        // Line back high at mid start bit is a glitch, not a frame.
                        if (!w_rx_sync) begin
                            w_state_next      = StData;
                            w_sample_cnt_next = '0;
                            w_bit_idx_next    = '0;
                        end else begin
                            w_state_next = StIdle;
                        end
                    end else begin
                        w_sample_cnt_next = r_sample_cnt + 4'd1;
                    end
                end
            end
            StData: begin
                if (w_tick) begin
                    if (r_sample_cnt == 4'd15) begin
                        w_shift_next      = {w_rx_sync, r_shift[7:1]};
                        w_sample_cnt_next = '0;
                        if (r_bit_idx == 3'd7) begin
                            w_state_next = StStop;
                        end else begin
                            w_bit_idx_next = r_bit_idx + 3'd1;
                        end
                    end else begin
                        w_sample_cnt_next = r_sample_cnt + 4'd1;
                    end
                end
            end
            StStop: begin
                if (w_tick) begin
                    if (r_sample_cnt == 4'd15) begin
                        w_sample_cnt_next = '0;
                        if (w_rx_sync && !bus.full) begin
                            w_state_next = StWrite;
                        end else if (w_rx_sync) begin
                            w_set_overrun = 1'b1;
                            w_state_next  = StIdle;
                        end else begin
                            w_set_frame  = 1'b1;
                            w_state_next = StBreak;
                        end
                    end else begin
                        w_sample_cnt_next = r_sample_cnt + 4'd1;
                    end
                end
            end
            StWrite: begin
                w_din_next   = r_shift;
                w_wr_en_next = 1'b1;
                w_state_next = StIdle;
            end
            StBreak: begin
                // Hold here while the line stays low so a break is not read as 0x00 frames.
                if (w_tick && w_rx_sync) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign bus.din      = r_din;
    assign bus.wrEn     = r_wr_en;
    assign bus.frameErr = r_frame_err;
    assign bus.overrun  = r_overrun;
    assign bus.busy     = (r_state != StIdle);

endmodule
